// File: rtl/pc_updater_pkg.sv
// Shared constants for the fetch-path PC logic: branch condition codes and PC step.
package pc_updater_pkg;

    localparam logic [2:0] COND_NEQ    = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GTE    = 3'b100;
    localparam logic [2:0] COND_LTE    = 3'b101;
    localparam logic [2:0] COND_OVFL   = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    localparam logic [15:0] PC_INC = 16'd2;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a 3-bit branch condition against the Z/N/V flags.
module branch_cond_eval
    import pc_updater_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    output logic       cond_true
);

    // Each arm reads only the flags it needs, so UNCOND never sees unknown flags.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_NEQ:    cond_true = !Z;
            COND_EQ:     cond_true = Z;
            COND_GT:     cond_true = !Z && !N;
            COND_LT:     cond_true = N;
            COND_GTE:    cond_true = Z || (!Z && !N);
            COND_LTE:    cond_true = N || Z;
            COND_OVFL:   cond_true = V;
            COND_UNCOND: cond_true = 1'b1;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_updater.sv
// Program-counter register with next-PC selection: +2 increment or branch target.
module pc_updater
    import pc_updater_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] InAddr,
    input  logic        branch,
    input  logic [2:0]  cond,
    input  logic        Z,
    input  logic        N,
    input  logic        V,
    output logic [15:0] OutAddr
);

    logic        cond_true;
    logic        taken;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic [15:0] next_pc;

    branch_cond_eval u_cond (
        .cond      (cond),
        .Z         (Z),
        .N         (N),
        .V         (V),
        .cond_true (cond_true)
    );

    // Branch gates the condition so a non-branch instruction never depends on flags.
    assign taken   = branch ? cond_true : 1'b0;
    assign pc_plus = pc + PC_INC;
    assign next_pc = taken ? InAddr : pc_plus;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 16'h0000;
        end else begin
            pc <= next_pc;
        end
    end

    assign OutAddr = pc;

endmodule

// File: tb/tb_pc_updater.sv
// Directed and randomized checks of pc_updater against a behavioural PC model.
module tb_pc_updater;

    logic        clk;
    logic        rst;
    logic [15:0] InAddr;
    logic        branch;
    logic [2:0]  cond;
    logic        Z;
    logic        N;
    logic        V;
    logic [15:0] OutAddr;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_pc;

    pc_updater dut (
        .clk     (clk),
        .rst     (rst),
        .InAddr  (InAddr),
        .branch  (branch),
        .cond    (cond),
        .Z       (Z),
        .N       (N),
        .V       (V),
        .OutAddr (OutAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags describe a compare result: zero, negative, overflow.
    function automatic bit cond_holds(input int code, input logic zf, input logic nf, input logic vf);
        bit is_zero, is_neg, is_pos;
        if (code == 7) return 1'b1;
        is_zero = (zf === 1'b1);
        is_neg  = (nf === 1'b1);
        is_pos  = !is_zero && !is_neg;
        if (code == 0) return !is_zero;
        if (code == 1) return is_zero;
        if (code == 2) return is_pos;
        if (code == 3) return is_neg;
        if (code == 4) return is_pos || is_zero;
        if (code == 5) return is_neg || is_zero;
        return (vf === 1'b1);
    endfunction

    function automatic logic [15:0] model_next(input logic [15:0] pc);
        int nxt;
        if (rst) return 16'h0000;
        if (branch && cond_holds(int'(cond), Z, N, V)) return InAddr;
        nxt = (int'(pc) + 2) % 65536;
        return nxt[15:0];
    endfunction

    task automatic tick(input string tag, input logic [15:0] want);
        @(posedge clk);
        #1;
        checks++;
        assert (OutAddr === want) else begin
            errors++;
            $error("FAIL %s: OutAddr=%h expected %h", tag, OutAddr, want);
        end
        model_pc = want;
    endtask

    initial begin
        rst = 1'b1; branch = 1'b0; cond = 3'b000; InAddr = 16'h0000;
        Z = 1'b0; N = 1'b0; V = 1'b0;
        model_pc = 16'h0000;

        tick("reset_0", 16'h0000);
        tick("reset_1", 16'h0000);
        rst = 1'b0;
        checks++;
        assert (OutAddr === 16'h0000) else begin
            errors++;
            $error("FAIL first_cycle_after_reset: OutAddr=%h expected %h", OutAddr, 16'h0000);
        end
        tick("run_2", 16'h0002);
        tick("run_4", 16'h0004);
        tick("run_6", 16'h0006);

        rst = 1'b1;
        tick("rereset", 16'h0000);
        rst = 1'b0;
        tick("rerun_2", 16'h0002);
        tick("rerun_4", 16'h0004);

        branch = 1'b1; InAddr = 16'd10;
        cond = 3'b000; Z = 1'b0; tick("neq_taken", 16'd10);
        cond = 3'b000; Z = 1'b1; tick("neq_not", 16'd12);
        cond = 3'b001; Z = 1'b1; InAddr = 16'd20; tick("eq_taken", 16'd20);
        cond = 3'b001; Z = 1'b0; tick("eq_not", 16'd22);

        InAddr = 16'd30;
        cond = 3'b010; Z = 1'b0; N = 1'b0; tick("gt_taken", 16'd30);
        cond = 3'b010; Z = 1'b1; N = 1'b0; tick("gt_not", 16'd32);
        cond = 3'b011; Z = 1'b0; N = 1'b1; tick("lt_taken", 16'd30);
        cond = 3'b011; Z = 1'b0; N = 1'b0; tick("lt_not", 16'd32);
        cond = 3'b100; Z = 1'b1; N = 1'b0; tick("gte_taken", 16'd30);
        cond = 3'b100; Z = 1'b0; N = 1'b1; tick("gte_not", 16'd32);
        cond = 3'b101; Z = 1'b0; N = 1'b0; tick("lte_not", 16'd34);
        cond = 3'b101; Z = 1'b0; N = 1'b1; tick("lte_taken", 16'd30);

        N = 1'b0;
        cond = 3'b110; V = 1'b0; tick("ovfl_not", 16'd32);
        cond = 3'b110; V = 1'b1; InAddr = 16'd80; tick("ovfl_taken", 16'd80);

        cond = 3'b111; Z = 1'bx; N = 1'bx; V = 1'bx; InAddr = 16'd90;
        tick("uncond_xflags", 16'd90);
        Z = 1'b0; N = 1'b0; V = 1'b0;

        branch = 1'b0; cond = 3'b111; tick("branch_gated", 16'd92);

        rst = 1'b1; branch = 1'b1; cond = 3'b111; tick("reset_priority", 16'h0000);
        rst = 1'b0;

        InAddr = 16'hFFFE; tick("jump_fffe", 16'hFFFE);
        branch = 1'b0; tick("wrap_0", 16'h0000);
        tick("wrap_2", 16'h0002);

        branch = 1'b1; cond = 3'b111; InAddr = 16'h1235; tick("odd_target", 16'h1235);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] want;
            rst    = ($urandom_range(0, 24) == 0);
            branch = $urandom_range(0, 1);
            cond   = 3'($urandom_range(0, 7));
            InAddr = 16'($urandom);
            if (cond == 3'b111 && $urandom_range(0, 1) == 1) begin
                Z = 1'bx; N = 1'bx; V = 1'bx;
            end else begin
                Z = $urandom_range(0, 1);
                N = $urandom_range(0, 1);
                V = $urandom_range(0, 1);
            end
            want = model_next(model_pc);
            tick("random", want);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
